// File: rtl/offnariscv_stage_buf.sv
// Pipeline stage buffer: a DEPTH-entry FIFO between two AXI-Stream-style ports.
// Handshake outputs decode registered state only; flush empties the buffer.
module offnariscv_stage_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign s_axis_tready = (count_q != CNT_WIDTH'(DEPTH));
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign count         = count_q;

  assign push = s_axis_tvalid && s_axis_tready && !flush;
  assign pop  = m_axis_tvalid && m_axis_tready && !flush;

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

endmodule

// File: doc/offnariscv_stage_buf.md
OFFNARISCV_STAGE_BUF -- requirements
Module: offnariscv_stage_buf

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32 (XLEN), meaning the tdata width in bits; any positive value is legal.
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning the number of entries; any value >= 1 is legal, including values that are not a power of two.
REQ-003 The module SHALL have parameter CNT_WIDTH, default $clog2(DEPTH+1), meaning the width of the count output.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port flush, input, 1 bit: pipeline flush (trap or mispredict); it discards all buffered beats.
REQ-007 Port s_axis_tdata, input, DATA_WIDTH bits: upstream payload (a packed *_tdata_t struct).
REQ-008 Port s_axis_tvalid, input, 1 bit: the upstream beat is valid.
REQ-009 Port s_axis_tready, output, 1 bit: the buffer can accept a beat.
REQ-010 Port m_axis_tdata, output, DATA_WIDTH bits: downstream payload, which is the oldest entry.
REQ-011 Port m_axis_tvalid, output, 1 bit: the downstream beat is valid.
REQ-012 Port m_axis_tready, input, 1 bit: downstream accepts the beat.
REQ-013 Port count, output, CNT_WIDTH bits: number of occupied entries (0..DEPTH).

Function
REQ-014 Push SHALL occur when s_axis_tvalid && s_axis_tready && !flush; pop SHALL occur when m_axis_tvalid && m_axis_tready && !flush.
REQ-015 s_axis_tready SHALL equal (count != DEPTH) and SHALL be driven from registered state only, with no combinational path from m_axis_tready or s_axis_tvalid.
REQ-016 m_axis_tvalid SHALL equal (count != 0) and SHALL be driven from registered state only.
REQ-017 Latency SHALL be 1 cycle: a beat pushed at edge N SHALL be visible on m_axis_* after edge N; there is no combinational bypass from s to m.
REQ-018 Order SHALL be strict FIFO; m_axis_tdata SHALL always present the oldest entry.
REQ-019 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata SHALL remain stable.
REQ-020 Read and write pointers SHALL each run 0..DEPTH-1 and wrap to 0 after DEPTH-1, with no power-of-two requirement.
REQ-021 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-022 When full, s_axis_tready=0, so no push occurs even if a pop occurs in the same cycle; s_axis_tready SHALL rise in the cycle after the pop.
REQ-023 When empty, no pop SHALL occur; a push SHALL make count=1 on the next cycle.
REQ-024 count SHALL be updated as count + push - pop, and SHALL never exceed DEPTH or underflow.
REQ-025 flush=1 at edge N SHALL set count=0 and both pointers=0 after edge N; a beat offered in the same cycle SHALL be dropped, and no pop SHALL be signalled for that cycle.
REQ-026 flush SHALL take priority over push and pop in every state.
REQ-027 Storage contents SHALL NOT be reset; only pointers and count SHALL be reset.
REQ-028 With DEPTH=1 the block SHALL behave as a half-rate register slice: accept, then drain, then accept again.

Reset
REQ-029 rst_n=0 SHALL immediately, asynchronously force count=0, pointers=0, m_axis_tvalid=0 and s_axis_tready=1.
REQ-030 Reset asserted mid-transfer SHALL discard all entries; after deassertion the first pushed beat SHALL be the first output.
REQ-031 While rst_n=0, s_axis_tvalid SHALL be ignored.
REQ-032 Reset deassertion SHALL be synchronised externally; the block SHALL operate correctly from the first rising edge after deassertion.

Verification
REQ-033 Fill/drain, DEPTH=2: push A, B with m_axis_tready=0 -> count=2, s_axis_tready=0; then m_axis_tready=1 -> output A, then B; count=0.
REQ-034 Streaming, DEPTH=3: continuous valid/ready for 10 beats, values 0..9 -> outputs 0..9 in order, 1-cycle latency, count constant at 1 after the first beat.
REQ-035 Wrap, DEPTH=3: 7 pushes and pops interleaved with random stalls -> order preserved across pointer wrap; pointers never reach 3.
REQ-036 Flush: count=2 with flush=1 and s_axis_tvalid=1 (value C) in the same cycle -> next cycle count=0, m_axis_tvalid=0; C is never output.
REQ-037 Async reset: assert rst_n=0 between clock edges while count=1 -> m_axis_tvalid=0 and s_axis_tready=1 before the next edge.
REQ-038 Backpressure stability: m_axis_tready=0 for 5 cycles with m_axis_tvalid=1 -> m_axis_tdata unchanged throughout.
